// File: rtl/similarity_arb_pkg.sv
// Shared types, FSM state codes and the round-robin pick helper for the
// similarity mapper request arbiter.
package similarity_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY    = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // Default-width aliases for code that talks to the mapper at its stock size
  typedef logic [4:0]  hv_addr_t;
  typedef logic [31:0] hv_data_t;

  typedef struct packed {
    logic                 any;
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_REQ-1:0]   onehot;
  } rr_pick_t;

  // First set request at or after ptr, wrapping at num; ptr must be below num
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int unsigned          num);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= num) k = k - num;
      if (i < num && !r.any && req[k[MAX_IDX_W-1:0]]) begin
        r.any                         = 1'b1;
        r.idx                         = k[MAX_IDX_W-1:0];
        r.onehot[k[MAX_IDX_W-1:0]]    = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/similarity_request_arbiter_rr_arbiter.sv
// Round-robin picker: combinational choice from the current pointer, and a
// registered pointer that moves just past the finished owner.
module rr_arbiter
  import similarity_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  input  logic [IDX_W-1:0]   i_owner,
  output logic               o_any,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0]     r_ptr;
  logic [MAX_REQ-1:0]   w_req_ext;
  logic [MAX_IDX_W-1:0] w_ptr_ext;
  rr_pick_t             w_pick;
  logic                 w_unused_pick;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
    w_ptr_ext                = '0;
    w_ptr_ext[IDX_W-1:0]     = r_ptr;
    w_pick                   = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
  end

  assign o_any         = w_pick.any;
  assign o_onehot      = w_pick.onehot[NUM_REQ-1:0];
  assign o_idx         = w_pick.idx[IDX_W-1:0];
  assign w_unused_pick = &{1'b0, w_pick};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (i_advance)
      r_ptr <= (i_owner == IDX_W'(NUM_REQ - 1)) ? '0 : i_owner + 1'b1;
  end

endmodule

// File: rtl/similarity_request_arbiter.sv
// Shares one SimilarityDirectMapper between NUM_REQ requesters with
// round-robin arbitration, range checking and a busy watchdog.
module similarity_request_arbiter
  import similarity_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int HV_DATA_WIDTH    = 32,
  parameter int HV_ADDRESS_WIDTH = 5,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_hva,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_hvb,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_start,
  input  logic [NUM_REQ*HV_ADDRESS_WIDTH-1:0] req_end,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [NUM_REQ-1:0]                  resp_err,
  output logic [HV_DATA_WIDTH-1:0]            resp_AA,
  output logic [HV_DATA_WIDTH-1:0]            resp_BB,
  output logic [HV_DATA_WIDTH-1:0]            resp_AB,
  output logic                                m_valid,
  output logic [HV_ADDRESS_WIDTH-1:0]         m_hva,
  output logic [HV_ADDRESS_WIDTH-1:0]         m_hvb,
  output logic [HV_ADDRESS_WIDTH-1:0]         m_hv_start,
  output logic [HV_ADDRESS_WIDTH-1:0]         m_hv_end,
  input  logic                                m_done,
  input  logic [HV_DATA_WIDTH-1:0]            m_AA,
  input  logic [HV_DATA_WIDTH-1:0]            m_BB,
  input  logic [HV_DATA_WIDTH-1:0]            m_AB
);

  localparam int                 IDX_W = $clog2(NUM_REQ);
  localparam int                 WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                 AW    = HV_ADDRESS_WIDTH;
  localparam logic [NUM_REQ-1:0] ONE   = 1;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_owner;
  logic [WD_W-1:0]          r_wdog;
  logic [AW-1:0]            r_hva, r_hvb, r_start, r_end;
  logic [NUM_REQ-1:0]       r_grant, r_resp_valid, r_resp_err;
  logic [HV_DATA_WIDTH-1:0] r_AA, r_BB, r_AB;

  logic                     w_any, w_busy, w_advance;
  logic [NUM_REQ-1:0]       w_onehot, w_owner_onehot;
  logic [IDX_W-1:0]         w_idx;
  logic [AW-1:0]            w_sel_hva, w_sel_hvb, w_sel_start, w_sel_end;

  assign w_busy         = (r_state == ST_BUSY);
  // Pointer only moves once the mapper has dropped done, never on a stale one
  assign w_advance      = (r_state == ST_RELEASE) && !m_done;
  assign w_owner_onehot = ONE << r_owner;

  assign w_sel_hva   = req_hva[w_idx*AW +: AW];
  assign w_sel_hvb   = req_hvb[w_idx*AW +: AW];
  assign w_sel_start = req_start[w_idx*AW +: AW];
  assign w_sel_end   = req_end[w_idx*AW +: AW];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_advance (w_advance),
    .i_owner   (r_owner),
    .o_any     (w_any),
    .o_onehot  (w_onehot),
    .o_idx     (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_wdog       <= '0;
      r_hva        <= '0;
      r_hvb        <= '0;
      r_start      <= '0;
      r_end        <= '0;
      r_grant      <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= '0;
      r_AA         <= '0;
      r_BB         <= '0;
      r_AB         <= '0;
    end else begin
      r_grant      <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_idx;
            r_hva   <= w_sel_hva;
            r_hvb   <= w_sel_hvb;
            r_start <= w_sel_start;
            r_end   <= w_sel_end;
            r_grant <= w_onehot;
            if (w_sel_start > w_sel_end) begin
              r_resp_err <= w_onehot;
              r_state    <= ST_RELEASE;
            end else begin
              r_state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_wdog <= r_wdog + 1'b1;
          // done has priority over an expiring watchdog in the same cycle
          if (m_done) begin
            r_AA         <= m_AA;
            r_BB         <= m_BB;
            r_AB         <= m_AB;
            r_resp_valid <= w_owner_onehot;
            r_state      <= ST_RELEASE;
          end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_resp_err   <= w_owner_onehot;
            r_state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!m_done) begin
            r_wdog  <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_AA    = r_AA;
  assign resp_BB    = r_BB;
  assign resp_AB    = r_AB;
  assign m_valid    = w_busy;
  assign m_hva      = w_busy ? r_hva   : '0;
  assign m_hvb      = w_busy ? r_hvb   : '0;
  assign m_hv_start = w_busy ? r_start : '0;
  assign m_hv_end   = w_busy ? r_end   : '0;

endmodule

// File: tb/tb_similarity_request_arbiter.sv
// Directed bench for similarity_request_arbiter with a behavioural mapper
// whose latency, stuck-done length and hang behaviour are set per scenario.
module tb_similarity_request_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req;
  logic [NR*AW-1:0]   req_hva, req_hvb, req_start, req_end;
  logic [NR-1:0]      grant, resp_valid, resp_err;
  logic [DW-1:0]      resp_AA, resp_BB, resp_AB;
  logic               m_valid;
  logic [AW-1:0]      m_hva, m_hvb, m_hv_start, m_hv_end;
  logic               m_done;
  logic [DW-1:0]      m_AA, m_BB, m_AB;

  int errors = 0;
  int checks = 0;

  int          mdl_latency = 10;
  int          mdl_sticky  = 0;
  bit          mdl_never   = 1'b0;
  logic [DW-1:0] mdl_AA = '0, mdl_BB = '0, mdl_AB = '0;
  int          mcount, mhold;

  always #5 clk = ~clk;

  similarity_request_arbiter #(
    .NUM_REQ(NR), .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_hva(req_hva), .req_hvb(req_hvb), .req_start(req_start), .req_end(req_end),
    .grant(grant), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_AA(resp_AA), .resp_BB(resp_BB), .resp_AB(resp_AB),
    .m_valid(m_valid), .m_hva(m_hva), .m_hvb(m_hvb),
    .m_hv_start(m_hv_start), .m_hv_end(m_hv_end),
    .m_done(m_done), .m_AA(m_AA), .m_BB(m_BB), .m_AB(m_AB)
  );

  // Mapper model: done after mdl_latency valid cycles, held until valid drops
  // plus mdl_sticky extra cycles; never raised while mdl_never is set.
  initial begin
    m_done = 1'b0; m_AA = '0; m_BB = '0; m_AB = '0; mcount = 0; mhold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_done = 1'b0; mcount = 0; mhold = 0;
      end else if (m_done) begin
        if (!m_valid) begin
          if (mhold == 0) begin m_done = 1'b0; mcount = 0; end
          else mhold--;
        end
      end else if (m_valid) begin
        mcount++;
        if (!mdl_never && mcount >= mdl_latency) begin
          m_done = 1'b1; m_AA = mdl_AA; m_BB = mdl_BB; m_AB = mdl_AB;
          mhold  = mdl_sticky;
        end
      end else begin
        mcount = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "[TB] bench stopped by time bound");
  end

  task automatic set_args(input int i, input int hva, input int hvb, input int st, input int en);
    req_hva[i*AW +: AW]   = AW'(hva);
    req_hvb[i*AW +: AW]   = AW'(hvb);
    req_start[i*AW +: AW] = AW'(st);
    req_end[i*AW +: AW]   = AW'(en);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    checks++; if ({grant, resp_valid, resp_err} !== '0) begin errors++;
      $display("[TB] FAIL reset_pulses: got %b required 0", {grant, resp_valid, resp_err}); end
    checks++; if (m_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_m_valid: got %b required 0", m_valid); end
    checks++; if ({resp_AA, resp_BB, resp_AB} !== '0) begin errors++;
      $display("[TB] FAIL reset_results: got %h required 0", {resp_AA, resp_BB, resp_AB}); end
    checks++; if ({m_hva, m_hvb, m_hv_start, m_hv_end} !== '0) begin errors++;
      $display("[TB] FAIL reset_m_args: got %h required 0", {m_hva, m_hvb, m_hv_start, m_hv_end}); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    int mv, at;
    set_args(0, 0, 4, 0, 1);
    mdl_latency = 10; mdl_sticky = 0; mdl_never = 1'b0;
    mdl_AA = 32'd5; mdl_BB = 32'd9; mdl_AB = 32'd3;
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL single_grant: got %b required 0001", grant); end
    checks++; if (m_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL single_m_valid_with_grant: got %b required 1", m_valid); end
    checks++; if ({m_hva, m_hvb, m_hv_start, m_hv_end} !== {5'd0, 5'd4, 5'd0, 5'd1}) begin errors++;
      $display("[TB] FAIL single_m_args: got %h required %h", {m_hva, m_hvb, m_hv_start, m_hv_end},
               {5'd0, 5'd4, 5'd0, 5'd1}); end
    req = '0;
    mv = 1; at = 0;
    for (int i = 2; i <= 40 && at == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0 || resp_err !== '0) at = i;
      else if (m_valid) mv++;
    end
    checks++; if (at != 11) begin errors++;
      $display("[TB] FAIL single_resp_cycle: got %0d required 11", at); end
    checks++; if (mv != 10) begin errors++;
      $display("[TB] FAIL single_m_valid_len: got %0d required 10", mv); end
    checks++; if (resp_valid !== 4'b0001 || resp_err !== 4'b0000) begin errors++;
      $display("[TB] FAIL single_resp_flags: got v=%b e=%b required v=0001 e=0000", resp_valid, resp_err); end
    checks++; if (resp_AA !== 32'd5 || resp_BB !== 32'd9 || resp_AB !== 32'd3) begin errors++;
      $display("[TB] FAIL single_results: got %0d/%0d/%0d required 5/9/3", resp_AA, resp_BB, resp_AB); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int gidx[$];
    int gcyc[$];
    int resp_n, g;
    logic [NR-1:0] last_grant;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < NR; i++) set_args(i, i + 1, i + 10, 0, 2);
    mdl_latency = 3; mdl_AA = 32'd7; mdl_BB = 32'd8; mdl_AB = 32'd9;
    resp_n = 0; last_grant = '0;
    req = 4'b1111;
    for (int cyc = 1; cyc <= 200 && resp_n < 5; cyc++) begin
      @(negedge clk);
      if (grant !== '0) begin
        g = 0;
        for (int k = 0; k < NR; k++) if (grant[k]) g = k;
        checks++; if (!$onehot(grant) || m_hva !== AW'(g + 1)) begin errors++;
          $display("[TB] FAIL fair_grant_args: grant=%b m_hva=%0d required one-hot with m_hva=%0d",
                   grant, m_hva, g + 1); end
        gidx.push_back(g);
        gcyc.push_back(cyc);
        last_grant = grant;
      end
      if (resp_valid !== '0) begin
        resp_n++;
        checks++; if (resp_valid !== last_grant) begin errors++;
          $display("[TB] FAIL fair_resp_owner: got %b required %b", resp_valid, last_grant); end
      end
    end
    req = '0;
    checks++; if (resp_n != 5 || gidx.size() != 5) begin errors++;
      $display("[TB] FAIL fair_counts: got %0d grants %0d responses required 5 and 5", gidx.size(), resp_n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (i >= gidx.size() || gidx[i] != exp_order[i]) begin errors++;
        $display("[TB] FAIL fair_order[%0d]: got %0d required %0d", i,
                 (i < gidx.size()) ? gidx[i] : -1, exp_order[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      checks++; if (i >= gcyc.size() || gcyc[i] - gcyc[i-1] != 5) begin errors++;
        $display("[TB] FAIL fair_turnaround[%0d]: got %0d required 5", i,
                 (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_invalid_range;
    logic mv_seen;
    int   at;
    set_args(2, 3, 7, 3, 1);
    mdl_latency = 3; mdl_AA = 32'd21; mdl_BB = 32'd22; mdl_AB = 32'd23;
    @(negedge clk); req = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0100 || resp_err !== 4'b0100) begin errors++;
      $display("[TB] FAIL inv_grant_err: got g=%b e=%b required g=0100 e=0100", grant, resp_err); end
    checks++; if (m_valid !== 1'b0 || resp_valid !== 4'b0000) begin errors++;
      $display("[TB] FAIL inv_no_issue: got mv=%b rv=%b required 0 and 0000", m_valid, resp_valid); end
    req = '0;
    set_args(2, 3, 12, 0, 2);
    @(negedge clk);
    mv_seen = m_valid;
    req = 4'b1111;
    @(negedge clk);
    checks++; if (mv_seen !== 1'b0) begin errors++;
      $display("[TB] FAIL inv_m_valid_after: got %b required 0", mv_seen); end
    checks++; if (grant !== 4'b1000) begin errors++;
      $display("[TB] FAIL inv_pointer_next: got %b required 1000", grant); end
    req = '0;
    at = 0;
    for (int i = 1; i <= 40 && at == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0 || resp_err !== '0) at = i;
    end
    checks++; if (resp_valid !== 4'b1000 || resp_AA !== 32'd21) begin errors++;
      $display("[TB] FAIL inv_followup_resp: got v=%b AA=%0d required v=1000 AA=21", resp_valid, resp_AA); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    int  mv, at;
    logic v_seen;
    mdl_never = 1'b1;
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL to_grant: got %b required 0001", grant); end
    req = '0;
    mv = 1; at = 0; v_seen = 1'b0;
    for (int i = 2; i <= 60 && at == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0) v_seen = 1'b1;
      if (resp_err !== '0) at = i;
      else if (m_valid) mv++;
    end
    checks++; if (at != 17 || mv != 16) begin errors++;
      $display("[TB] FAIL to_timing: got err at %0d busy %0d required 17 and 16", at, mv); end
    checks++; if (resp_err !== 4'b0001 || m_valid !== 1'b0 || v_seen !== 1'b0) begin errors++;
      $display("[TB] FAIL to_flags: got e=%b mv=%b vseen=%b required 0001 0 0", resp_err, m_valid, v_seen); end
    checks++; if (resp_AA !== 32'd21 || resp_BB !== 32'd22 || resp_AB !== 32'd23) begin errors++;
      $display("[TB] FAIL to_results_kept: got %0d/%0d/%0d required 21/22/23", resp_AA, resp_BB, resp_AB); end
    mdl_never = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sticky_done;
    int g1, resp_n, mv, at;
    logic [NR-1:0] gval;
    mdl_latency = 4; mdl_sticky = 3;
    mdl_AA = 32'd31; mdl_BB = 32'd32; mdl_AB = 32'd33;
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    req = 4'b0010;
    g1 = 0; resp_n = 0; mv = 0; gval = '0;
    for (int i = 2; i <= 40 && g1 == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0) begin
        resp_n++;
        checks++; if (resp_valid !== 4'b0001 || resp_AA !== 32'd31) begin errors++;
          $display("[TB] FAIL sticky_first_resp: got v=%b AA=%0d required 0001 31", resp_valid, resp_AA); end
      end
      if (grant !== '0) begin g1 = i; gval = grant; end
      else if (m_valid) mv++;
    end
    checks++; if (g1 != 10 || gval !== 4'b0010) begin errors++;
      $display("[TB] FAIL sticky_grant: got %b at %0d required 0010 at 10", gval, g1); end
    checks++; if (resp_n != 1 || mv != 3) begin errors++;
      $display("[TB] FAIL sticky_no_dup: got %0d resp %0d busy required 1 and 3", resp_n, mv); end
    req = '0; mdl_sticky = 0;
    at = 0; resp_n = 0;
    for (int i = 1; i <= 40 && at == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0 || resp_err !== '0) begin at = i; resp_n++; end
    end
    checks++; if (at != 4 || resp_valid !== 4'b0010) begin errors++;
      $display("[TB] FAIL sticky_second_job: got v=%b at %0d required 0010 at 4", resp_valid, at); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    logic [3*NR-1:0] pulses;
    int at;
    mdl_latency = 10; mdl_AA = 32'd41; mdl_BB = 32'd42; mdl_AB = 32'd43;
    @(negedge clk); req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++;
      $display("[TB] FAIL rst_mid_grant: got %b required 0010", grant); end
    req = '0;
    repeat (4) @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL rst_mid_busy: got %b required 1", m_valid); end
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    checks++; if (m_valid !== 1'b0 || {m_hva, m_hvb, m_hv_start, m_hv_end} !== '0) begin errors++;
      $display("[TB] FAIL rst_mid_m_clear: got mv=%b args=%h required 0", m_valid,
               {m_hva, m_hvb, m_hv_start, m_hv_end}); end
    checks++; if ({resp_AA, resp_BB, resp_AB} !== '0 || {grant, resp_valid, resp_err} !== '0) begin errors++;
      $display("[TB] FAIL rst_mid_outputs: got res=%h pulses=%b required 0", {resp_AA, resp_BB, resp_AB},
               {grant, resp_valid, resp_err}); end
    pulses = '0;
    repeat (2) begin @(negedge clk); pulses = pulses | {grant, resp_valid, resp_err}; end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pulses !== '0) begin errors++;
      $display("[TB] FAIL rst_mid_no_pulse: got %b required 0", pulses); end
    checks++; if (grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL rst_mid_ptr_zero: got %b required 0001", grant); end
    req = '0;
    at = 0;
    for (int i = 1; i <= 40 && at == 0; i++) begin
      @(negedge clk);
      if (resp_valid !== '0 || resp_err !== '0) at = i;
    end
    checks++; if (resp_valid !== 4'b0001 || resp_AA !== 32'd41 || resp_AB !== 32'd43) begin errors++;
      $display("[TB] FAIL rst_mid_rejob: got v=%b AA=%0d AB=%0d required 0001 41 43", resp_valid, resp_AA, resp_AB); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    req_hva = '0; req_hvb = '0; req_start = '0; req_end = '0;
    for (int i = 0; i < NR; i++) set_args(i, i + 1, i + 8, 0, 2);
    test_reset();
    test_single();
    test_fairness();
    test_invalid_range();
    test_timeout();
    test_sticky_done();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/similarity_request_arbiter.md
Name: similarity_request_arbiter

Overview:
- Shares one SimilarityDirectMapper instance between NUM_REQ requesters, e.g. per-class query engines or a host port.
- Each requester posts hypervector addresses and gets back the AA/BB/AB results of its own job only.
- Arbitration is round-robin. The block drives the mapper's level valid/done handshake and adds a watchdog and range checking.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HV_DATA_WIDTH, 32, width of each similarity result.
- HV_ADDRESS_WIDTH, 5, dpram address width.
- TIMEOUT_CYCLES, 1024, maximum cycles a mapper job may stay busy before it is aborted.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_hva  in  NUM_REQ*HV_ADDRESS_WIDTH  packed base address of hypervector A; requester i occupies bits [i*W +: W].
- req_hvb  in  NUM_REQ*HV_ADDRESS_WIDTH  packed base address of hypervector B.
- req_start  in  NUM_REQ*HV_ADDRESS_WIDTH  packed first word offset.
- req_end  in  NUM_REQ*HV_ADDRESS_WIDTH  packed last word offset.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: the requester's arguments were captured.
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse: results are valid for that requester.
- resp_err  out  NUM_REQ  one-hot, one-cycle pulse: the job was rejected or timed out.
- resp_AA, resp_BB, resp_AB  out  HV_DATA_WIDTH each  result registers, shared by all requesters.
- m_valid  out  1  mapper valid.
- m_hva, m_hvb, m_hv_start, m_hv_end  out  HV_ADDRESS_WIDTH each  mapper arguments.
- m_done  in  1  mapper done.
- m_AA, m_BB, m_AB  in  HV_DATA_WIDTH each  mapper results.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, watchdog 0, owner 0.
- Requester contract:
  - Hold req until grant.
  - Keep arguments stable while req is high.
  - Dropping req before grant withdraws the request with no side effects.
  - A req still high after the response is treated as a new request.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, wrapping from NUM_REQ-1 to 0.
  - Register owner and that requester's arguments, and pulse grant[owner] on the next cycle.
  - If req_start > req_end, pulse resp_err[owner] together with grant, do not issue, and go to RELEASE.
  - Otherwise go to BUSY.
- BUSY:
  - m_valid=1; m_* outputs driven from the captured argument registers.
  - The watchdog increments every cycle.
  - On m_done=1: capture m_AA/m_BB/m_AB into resp_*, pulse resp_valid[owner] on the following cycle, and go to RELEASE.
  - If the watchdog reaches TIMEOUT_CYCLES with m_done=0: pulse resp_err[owner] and go to RELEASE; resp_* are left unchanged.
  - If m_done and timeout occur in the same cycle, m_done wins.
- RELEASE:
  - m_valid=0.
  - Stay until m_done=0, so a stale done is never taken as the next job's result.
  - Then set pointer = owner+1 (mod NUM_REQ), clear the watchdog, and return to IDLE.
- Latency: req asserted → grant 1 cycle → m_valid high on the same cycle as grant.
  - resp_valid arrives 1 cycle after m_done.
  - Minimum turnaround between back-to-back jobs: 2 cycles with m_valid low.
- Requests raised while not in IDLE are held until IDLE; none are lost.
- resp_* hold their last value until the next successful job.
- Reset mid-job: everything clears immediately, m_valid drops asynchronously, and no response pulse is produced. Requesters re-request.

Decomposition:
- Package similarity_arb_pkg:
  - state enum {IDLE, BUSY, RELEASE}.
  - Address and data type aliases.
  - Function rr_pick(req, ptr) returning a one-hot vector plus an index.
- Sub-module rr_arbiter (combinational round-robin pick plus the registered pointer update), reusable elsewhere.
- FSM, watchdog and argument muxing stay in the top.

Test Plan:
- Single request: req=4'b0001, hva=0, hvb=4, start=0, end=1; mapper model asserts done after 10 cycles with AA=5, BB=9, AB=3. Expect grant[0] 1 cycle after req, m_valid high for 10 cycles, resp_valid[0] with resp_AA=5, resp_BB=9, resp_AB=3.
- Fairness: req=4'b1111 held continuously. Expect grants in order 0,1,2,3,0 with no requester skipped and exactly one response per grant.
- Invalid range: requester 2 with start=3, end=1. Expect grant[2] and resp_err[2] in the same cycle, m_valid never asserted, pointer advanced to 3.
- Timeout: TIMEOUT_CYCLES=16, mapper never asserts done. Expect resp_err[owner] at cycle 16, m_valid low, resp_* unchanged from the previous job.
- Sticky done: mapper holds done for 3 extra cycles while requester 1 is pending. Expect m_valid to stay low until done falls, then grant[1]; results are not duplicated.
- Reset mid-BUSY: assert reset at cycle 5 of a job. Expect all outputs 0 immediately; after release, a pending req is granted normally from pointer 0.
